// File: rtl/data_mem_responder.sv
// Data memory with a 4-entry posted write buffer in front of a DEPTH x 32 array.
// Reads forward from the youngest matching buffered write, else from the array.
module data_mem_responder #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memw,
  input  logic [31:0] m_address,
  input  logic [31:0] m_data,
  output logic [31:0] input_data,
  output logic [2:0]  wbuf_count,
  output logic        wbuf_empty
);

  logic [AW-1:0] word_idx;
  logic          unused_addr_bits;

  logic [31:0]   mem_q [DEPTH];

  logic [3:0]    valid_q, valid_d;
  logic [AW-1:0] idx_q  [4];
  logic [31:0]   data_q [4];
  logic [1:0]    head_q, head_d;
  logic [1:0]    tail_q, tail_d;
  logic [2:0]    count_q, count_d;

  logic          enq;
  logic          drain;
  logic [3:0]    hit;

  assign word_idx         = m_address[AW+1:2];
  assign unused_addr_bits = ^{m_address[31:AW+2], m_address[1:0]};

  // A full buffer drains its head on the same edge it accepts a new write,
  // so the processor never stalls and no write is dropped.
  always_comb begin
    enq   = memw & ~rst;
    drain = ~rst & ((~memw & (count_q != 3'd0)) | (memw & (count_q == 3'd4)));
  end

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 2'd1;
    end
    if (enq) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 2'd1;
    end
    if (enq && !drain) begin
      count_d = count_q + 3'd1;
    end else if (drain && !enq) begin
      count_d = count_q - 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 4'b0000;
      head_q  <= 2'd0;
      tail_q  <= 2'd0;
      count_q <= 3'd0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload and array contents carry no reset; validity alone gates them.
  always_ff @(posedge clk) begin
    if (enq) begin
      idx_q[tail_q]  <= word_idx;
      data_q[tail_q] <= m_data;
    end
  end

  always_ff @(posedge clk) begin
    if (drain) begin
      mem_q[idx_q[head_q]] <= data_q[head_q];
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_hit
    assign hit[gi] = valid_q[gi] & (idx_q[gi] == word_idx);
  end

  // Walk oldest to youngest so the last hit taken is the youngest write.
  always_comb begin
    logic [1:0] pos;
    pos        = head_q;
    input_data = mem_q[word_idx];
    for (int k = 0; k < 4; k++) begin
      pos = head_q + 2'(k);
      if (hit[pos]) begin
        input_data = data_q[pos];
      end
    end
  end

  assign wbuf_count = count_q;
  assign wbuf_empty = (count_q == 3'd0);

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, meaning number of 32-bit words in the internal data array (power of two, 16..4096).
REQ-002 Parameter AW, default 8, meaning word-address width; SHALL equal log2(DEPTH).
REQ-003 Port clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port memw  input  1  write enable from the processor memory stage.
REQ-006 Port m_address  input  32  byte address from the processor memory stage.
REQ-007 Port m_data  input  32  write data from the processor memory stage.
REQ-008 Port input_data  output  32  read data returned to the processor, combinational.
REQ-009 Port wbuf_count  output  3  number of valid write-buffer entries, 0..4.
REQ-010 Port wbuf_empty  output  1  high when wbuf_count is 0.

Function
REQ-011 Word index SHALL be m_address[AW+1:2]; bits [1:0] and bits above AW+1 ignored (addresses wrap modulo DEPTH words).
REQ-012 Block SHALL contain a DEPTH x 32 array with one write port and one asynchronous read port.
REQ-013 Block SHALL contain a 4-entry FIFO write buffer; each entry holds {valid, word index, data}; head/tail pointers 2 bits, wrap 3->0.
REQ-014 memw=1 at a rising edge SHALL enqueue {index, m_data} at tail; count +1 unless a simultaneous drain occurs.
REQ-015 Drain: at a rising edge with memw=0 and count>0, head entry SHALL be written to the array and dequeued; count -1.
REQ-016 Full case: memw=1 with count=4 SHALL drain head and enqueue new entry in the same edge; count stays 4; no write lost, no stall.
REQ-017 memw=1 with count<4 SHALL NOT drain; array unchanged that edge.
REQ-018 Read: input_data SHALL equal data of the youngest valid buffer entry whose index matches, else array[index].
REQ-019 Multiple matching entries: youngest (closest to tail) SHALL win.
REQ-020 The write presented in the current cycle (memw=1) SHALL NOT be visible on input_data until after the edge that enqueues it.
REQ-021 Drained entries SHALL be read from the array with identical value; draining SHALL not change input_data for any address.
REQ-022 Write-buffer order SHALL be preserved: array writes occur in enqueue order, so the final array value for an index is the last write to it.
REQ-023 wbuf_count and wbuf_empty SHALL be registered-state derived, no combinational path from memw.

Reset
REQ-024 rst=1 SHALL immediately clear all valid bits, head, tail and count; wbuf_count=0, wbuf_empty=1.
REQ-025 Pending (undrained) writes at reset SHALL be discarded; array contents SHALL be retained, not cleared.
REQ-026 While rst=1, enqueue and drain SHALL be inhibited; input_data SHALL equal array[index].
REQ-027 First enqueue SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-028 Write 0xDEADBEEF to 0x10 (memw=1, one cycle), then memw=0 read 0x10 -> input_data=0xDEADBEEF next cycle, count 1 then 0 after one idle edge.
REQ-029 Five consecutive writes to 0x00,0x04,0x08,0x0C,0x10 (data 1..5) -> count 1,2,3,4,4; array[0]=1 after 5th edge; reads of all five return 1..5.
REQ-030 Writes 0xA then 0xB to 0x20 back-to-back, read 0x20 while both buffered -> 0xB; after full drain read -> 0xB.
REQ-031 Write to 0x400 with DEPTH=256 -> read 0x000 returns the same data (wrap); address 0x403 aliases 0x400.
REQ-032 Three writes buffered, assert rst mid-cycle -> count=0 and wbuf_empty=1 immediately; reads return pre-write array values.
REQ-033 Read 0x30 while memw=1 writing 0x55 to 0x30 -> input_data shows old value that cycle, 0x55 the following cycle.
